// File: rtl/rv_pkg.sv
// Shared integer-core constants and types used by the register file and its scoreboard.
package rv_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int N_REGS      = 32;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage : rv_pkg

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer, detects
// RAW/WAW hazards for the issuing instruction and counts stalled issue cycles.
module regfile_sb_scoreboard #(
  parameter int N_REGS = rv_pkg::N_REGS,
  parameter int ADDR_W = rv_pkg::REG_ADDR_W,
  parameter int CNT_W  = rv_pkg::STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [N_REGS-1:0] busy;
  logic [N_REGS-1:0] busy_nxt;
  logic              busy_eff_rs1;
  logic              busy_eff_rs2;
  logic              busy_eff_rd;
  logic              raw;
  logic              waw;
  logic              iss_fire;

  // A register whose producer is writing back this very cycle is no longer a
  // hazard: the bypass supplies the value. x0 is never a hazard.
  always_comb begin
    busy_eff_rs1 = busy[rs1_addr] && !(wb_valid && (wb_rd == rs1_addr)) && (rs1_addr != '0);
    busy_eff_rs2 = busy[rs2_addr] && !(wb_valid && (wb_rd == rs2_addr)) && (rs2_addr != '0);
    busy_eff_rd  = busy[iss_rd]   && !(wb_valid && (wb_rd == iss_rd))   && (iss_rd   != '0);
    raw          = busy_eff_rs1 || busy_eff_rs2;
    waw          = busy_eff_rd;
  end

  // Issue handshake: iss_ready is a pure function of hazards (never of
  // iss_valid); an instruction is accepted on a rising edge where both
  // iss_valid and iss_ready are high, and the issuer must hold its fields
  // stable while iss_valid is high and iss_ready is low.
  assign iss_ready = !rst && !raw && !waw;
  assign iss_fire  = iss_valid && iss_ready;

  // Next busy vector: write-back clears first, then a new producer sets, so a
  // same-cycle issue to the retiring rd leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (iss_fire && (iss_rd != '0)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Saturating count of cycles where an instruction waited on a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (iss_valid && !iss_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and an integrated scoreboard.
// Feeds rs1/rs2 operands straight into the issue-stage operand muxes.
// ADDR_W is expected to equal $clog2(N_REGS).
module regfile_sb #(
  parameter int WIDTH  = rv_pkg::XLEN,
  parameter int N_REGS = rv_pkg::N_REGS,
  parameter int ADDR_W = rv_pkg::REG_ADDR_W,
  parameter int CNT_W  = rv_pkg::STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [WIDTH-1:0] regs [N_REGS];

  // Storage array; x0 is never written, so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Zero-latency read ports: x0 reads zero, a same-cycle write-back wins over the array.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wb_valid && (wb_rd == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wb_valid && (wb_rd == rs2_addr)) begin
      rs2_data = wb_data;
    end
  end

  regfile_sb_scoreboard #(
    .N_REGS (N_REGS),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .stall_cnt (stall_cnt)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reads, bypass, x0 handling, hazards,
// same-cycle issue/write-back, reset and stall-counter saturation.
module tb_regfile_sb;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  // clock / reset block
  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [W-1:0]  rs1_data;
  logic [W-1:0]  rs2_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          iss_ready;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .stall_cnt (stall_cnt)
  );

  // scoreboard
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: advance past the edge, then inputs may be changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    iss_valid = 1'b0;
    iss_rd    = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    rs1_addr  = '0;
    rs2_addr  = '0;
  endtask

  task automatic drive_wb(input logic [AW-1:0] rd, input logic [W-1:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
  endtask

  task automatic drive_iss(input logic [AW-1:0] rd, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    iss_valid = 1'b1;
    iss_rd    = rd;
    rs1_addr  = s1;
    rs2_addr  = s2;
  endtask

  logic [W-1:0] pattern [4];

  initial begin
    pattern[0] = 32'h0000_0001;
    pattern[1] = 32'hFFFF_FFFF;
    pattern[2] = 32'hA5A5_5A5A;
    pattern[3] = 32'h8000_0000;

    rst = 1'b1;
    drive_idle();
    tick();
    settle();
    check_eq("ready_in_reset", {31'b0, iss_ready}, 32'd0);
    tick();
    rst = 1'b0;

    // reset state
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    settle();
    check_eq("reset_rs1_x5", rs1_data, 32'd0);
    check_eq("reset_rs2_x0", rs2_data, 32'd0);
    check_eq("reset_ready", {31'b0, iss_ready}, 32'd1);
    check_eq("reset_stall", {16'b0, stall_cnt}, 32'd0);

    // bypass then array read
    rs1_addr = 5'd3;
    drive_wb(5'd3, 32'hDEAD_BEEF);
    settle();
    check_eq("bypass_x3", rs1_data, 32'hDEAD_BEEF);
    tick();
    wb_valid = 1'b0;
    settle();
    check_eq("array_x3", rs1_data, 32'hDEAD_BEEF);

    // write to x0 ignored, x0 never busy
    drive_iss(5'd0, 5'd0, 5'd0);
    drive_wb(5'd0, 32'h0000_1234);
    settle();
    check_eq("x0_bypass_blocked", rs1_data, 32'd0);
    check_eq("x0_iss_ready", {31'b0, iss_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    settle();
    check_eq("x0_after_write", rs1_data, 32'd0);
    check_eq("x0_not_busy", {31'b0, iss_ready}, 32'd1);
    drive_idle();

    // RAW stall on x7 and release by write-back
    drive_iss(5'd7, 5'd0, 5'd0);
    settle();
    check_eq("iss7_ready", {31'b0, iss_ready}, 32'd1);
    tick();
    drive_iss(5'd8, 5'd0, 5'd7);
    settle();
    check_eq("raw7_stall", {31'b0, iss_ready}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq($sformatf("stall_cnt_%0d", i), {16'b0, stall_cnt}, i);
    end
    drive_wb(5'd7, 32'd42);
    settle();
    check_eq("raw7_release", {31'b0, iss_ready}, 32'd1);
    check_eq("raw7_bypass", rs2_data, 32'd42);
    check_eq("raw7_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    tick();
    drive_idle();
    rs2_addr = 5'd7;
    settle();
    check_eq("x7_array", rs2_data, 32'd42);
    check_eq("stall_hold", {16'b0, stall_cnt}, 32'd3);
    drive_idle();

    // WAW then same-cycle issue/write-back on x9
    drive_iss(5'd9, 5'd0, 5'd0);
    tick();
    settle();
    check_eq("waw9_stall", {31'b0, iss_ready}, 32'd0);
    drive_wb(5'd9, 32'h0000_0099);
    settle();
    check_eq("same9_ready", {31'b0, iss_ready}, 32'd1);
    tick();
    drive_idle();
    drive_iss(5'd0, 5'd9, 5'd0);
    settle();
    check_eq("x9_still_busy", {31'b0, iss_ready}, 32'd0);
    check_eq("x9_data", rs1_data, 32'h0000_0099);
    drive_idle();
    drive_wb(5'd9, 32'h0000_0999);
    tick();
    drive_idle();

    // fill x1..x4 and read back through the expected queue
    for (int i = 0; i < 4; i++) begin
      drive_wb(AW'(i + 1), pattern[i]);
      exp_q.push_back(pattern[i]);
      tick();
    end
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      rs1_addr = AW'(i + 1);
      rs2_addr = AW'(4 - i);
      settle();
      check_eq($sformatf("fill_rs1_x%0d", i + 1), rs1_data, exp_q.pop_front());
      check_eq($sformatf("fill_rs2_x%0d", 4 - i), rs2_data, pattern[3 - i]);
    end

    // reset in the middle of a stall with a write-back in flight
    drive_idle();
    drive_iss(5'd4, 5'd0, 5'd0);
    tick();
    drive_iss(5'd0, 5'd4, 5'd1);
    settle();
    check_eq("x4_stall", {31'b0, iss_ready}, 32'd0);
    tick();
    check_eq("x4_stall_cnt", {16'b0, stall_cnt}, 32'd4);
    rst = 1'b1;
    drive_wb(5'd4, 32'h0000_4444);
    settle();
    check_eq("rst_ready_low", {31'b0, iss_ready}, 32'd0);
    tick();
    rst = 1'b0;
    wb_valid = 1'b0;
    settle();
    check_eq("post_rst_stall", {16'b0, stall_cnt}, 32'd0);
    check_eq("post_rst_ready", {31'b0, iss_ready}, 32'd1);
    check_eq("post_rst_x4", rs1_data, 32'd0);
    check_eq("post_rst_x1", rs2_data, 32'd0);
    rs1_addr = 5'd9;
    rs2_addr = 5'd7;
    settle();
    check_eq("post_rst_x9", rs1_data, 32'd0);
    check_eq("post_rst_x7", rs2_data, 32'd0);

    // stall counter saturation
    drive_idle();
    drive_iss(5'd4, 5'd0, 5'd0);
    tick();
    drive_iss(5'd0, 5'd4, 5'd0);
    repeat (65534) @(posedge clk);
    #1;
    check_eq("stall_fffe", {16'b0, stall_cnt}, 32'h0000_FFFE);
    tick();
    check_eq("stall_ffff", {16'b0, stall_cnt}, 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stall_sat", {16'b0, stall_cnt}, 32'h0000_FFFF);
    drive_idle();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file with integrated scoreboard; sits directly upstream of the operand-select muxes (muxr) in decode/issue and supplies their rs1/rs2 data inputs.
- Provides 2 combinational read ports with write-back bypass, 1 write-back port, and per-register busy tracking.
- Issue handshake stalls on RAW/WAW hazards; a saturating counter records stall cycles for performance debug.

Parameters:
- WIDTH, 32, data width of each register (XLEN)
- N_REGS, 32, number of architectural registers; register 0 hardwired to zero
- ADDR_W, 5, register address width; must equal $clog2(N_REGS)
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs1_addr  input  ADDR_W  source register 1 index
- rs2_addr  input  ADDR_W  source register 2 index
- rs1_data  output  WIDTH  source 1 operand, to operand mux
- rs2_data  output  WIDTH  source 2 operand, to operand mux
- iss_valid  input  1  issuing instruction present; rs1/rs2/iss_rd are its fields
- iss_rd  input  ADDR_W  destination of issuing instruction (0 = no destination)
- iss_ready  output  1  issue accepted this cycle
- wb_valid  input  1  write-back valid
- wb_rd  input  ADDR_W  write-back destination
- wb_data  input  WIDTH  write-back value
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at clk edge): all registers 0, all busy bits 0, stall_cnt 0; reset dominates every other event in that cycle, including a mid-flight write-back or issue.
- Read, combinational, zero latency:
  - rsN_data = 0 when rsN_addr == 0.
  - Otherwise, if wb_valid && wb_rd == rsN_addr, rsN_data = wb_data (bypass).
  - Otherwise, rsN_data = reg[rsN_addr].
- Write: on the clk edge with wb_valid && wb_rd != 0, reg[wb_rd] <= wb_data. Writes to register 0 are ignored.
- Effective busy, per source: busy_eff(a) = busy[a] && !(wb_valid && wb_rd == a) && a != 0.
- Hazards:
  - raw = busy_eff(rs1_addr) || busy_eff(rs2_addr)
  - waw = busy_eff(iss_rd)
  - iss_ready = !rst && !raw && !waw. iss_ready is combinational and independent of iss_valid.
- Fire: iss_fire = iss_valid && iss_ready.
- Busy update at clk edge, in priority order:
  - wb_valid clears busy[wb_rd].
  - Then iss_fire && iss_rd != 0 sets busy[iss_rd].
  - If the issue and the write-back target the same rd in the same cycle, busy ends set: the new producer wins.
  - busy[0] is never set.
- A write-back to a non-busy register is legal: data is written and busy stays 0.
- Stall counter: increments when iss_valid && !iss_ready; saturates at 2^CNT_W-1 with no wrap; cleared only by rst.
- No internal pipelining: a write-back is visible to reads in the same cycle via the bypass, and from the array on the next cycle.

Decomposition:
- Shared package rv_pkg holds XLEN=32, REG_ADDR_W=5, N_REGS=32 and typedefs reg_addr_t (logic [4:0]) and xlen_t (logic [31:0]). Parameter defaults are taken from the package.
- One sub-module, scoreboard: the busy vector, hazard logic, iss_ready and stall_cnt.
- regfile_sb instantiates scoreboard and contains the storage array and bypass itself.

Test Plan:
- Reset then read x5 and x0 → rs1_data=0, rs2_data=0; iss_ready=1; stall_cnt=0.
- Write-back wb_rd=3, wb_data=0xDEADBEEF with rs1_addr=3 in the same cycle → rs1_data=0xDEADBEEF in that cycle (bypass); next cycle with wb_valid=0 → still 0xDEADBEEF from the array.
- Write-back wb_rd=0, wb_data=0x1234 → rs1_addr=0 reads 0; x0 is never reported busy.
- Issue iss_rd=7 (fire); next cycle issue with rs2_addr=7 → iss_ready=0, stall_cnt increments each cycle. After 3 stall cycles, wb_rd=7, wb_data=42 → iss_ready=1 in the wb cycle, rs2_data=42, stall_cnt=3.
- Same-cycle iss_fire iss_rd=9 and wb_valid wb_rd=9 with busy[9]=1 → busy[9] stays 1; the next issue reading x9 stalls.
- Set busy[4], assert rst mid-stall → after the edge, busy clear, registers 0, stall_cnt=0, iss_ready=1. Separately, force 65535 stall cycles → stall_cnt holds at 0xFFFF.
